fetch_unit: RTL and testbench

- IF stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID latch.
- Consumes the hazard controller's PCselect, PCEN, IFIDEN and IFIDflush.
- Owns the PC register, next-PC selection, the icache read handshake and the IF/ID instruction/NPC register.
- Stops fetching permanently after a retired HALT.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit_if_id_reg.sv | 67 ++++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/hazard types: PC source select, fetch FSM states, NOP encoding.
// Imported by fetch_unit_if, fetch_unit and if_id_reg.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PCNPC = 2'd0,
    PCBPC = 2'd1,
    PCPTA = 2'd2,
    PCJPC = 2'd3
  } pcselect_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of icache, hazard-control and IF/ID signals around the fetch stage.
// master = fetch unit side, slave = surrounding pipeline/icache side.
interface fetch_unit_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic                       ihit;
  logic [WORD_W-1:0]          imemload;
  logic                       iREN;
  logic [WORD_W-1:0]          imemaddr;
  fetch_unit_pkg::pcselect_t  PCselect;
  logic                       PCEN;
  logic                       IFIDEN;
  logic                       IFIDflush;
  logic [WORD_W-1:0]          BPC;
  logic [WORD_W-1:0]          PTA;
  logic [WORD_W-1:0]          JPC;
  logic                       WBhalt;
  logic [WORD_W-1:0]          IDinstr;
  logic [WORD_W-1:0]          IDnpc;
  logic                       IDvalid;
  logic                       halted;

  modport master (
    input  ihit, imemload, PCselect, PCEN, IFIDEN, IFIDflush,
           BPC, PTA, JPC, WBhalt,
    output iREN, imemaddr, IDinstr, IDnpc, IDvalid, halted
  );

  modport slave (
    output ihit, imemload, PCselect, PCEN, IFIDEN, IFIDflush,
           BPC, PTA, JPC, WBhalt,
    input  iREN, imemaddr, IDinstr, IDnpc, IDvalid, halted
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// Generic pipeline latch: flush beats enable; an enabled cycle without a valid
// word loads a NOP bubble.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] npc_in,
  output logic [W-1:0] instr_out,
  output logic [W-1:0] npc_out,
  output logic         valid_out
);

  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] npc_q, npc_d;
  logic         valid_q, valid_d;

  // next latch contents
  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = W'(NOP_INSTR);
      npc_d   = {W{1'b0}};
      valid_d = 1'b0;
    end else if (en) begin
      if (load) begin
        instr_d = instr_in;
        npc_d   = npc_in;
        valid_d = 1'b1;
      end else begin
        instr_d = W'(NOP_INSTR);
        npc_d   = {W{1'b0}};
        valid_d = 1'b0;
      end
    end else begin
      instr_d = instr_q;
      npc_d   = npc_q;
      valid_d = valid_q;
    end
  end

  // latch state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= W'(NOP_INSTR);
      npc_q   <= {W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign npc_out   = npc_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, next-PC/redirect selection, icache handshake, IF/ID latch.
// Optional macro FETCH_BUF_EN adds a one-entry fetch buffer that holds a hit across stalls.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        WORD_W   = 32,
  parameter logic [WORD_W-1:0]  PC_RESET = 32'h0000_0000
) (
  input  logic           CLK,
  input  logic           RST,
  fetch_unit_if.master   fif
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] redir_q, redir_d;
  logic              pend_q, pend_d;
  logic [WORD_W-1:0] npc_s;
  logic [WORD_W-1:0] target_s;
  logic              run_s;
  logic              redirect_s;
  logic              ifid_en_s;
  logic              ifid_flush_s;
  logic              ifid_load_s;
  logic [WORD_W-1:0] ifid_word_s;

  assign run_s        = (state_q == ST_RUN);
  assign npc_s        = pc_q + {{(WORD_W-3){1'b0}}, 3'd4};
  assign redirect_s   = run_s & fif.PCEN & ((fif.PCselect != PCNPC) | pend_q);
  assign ifid_en_s    = run_s & fif.IFIDEN;
  assign ifid_flush_s = run_s & fif.IFIDflush;

  // redirect target mux
  always_comb begin
    target_s = npc_s;
    case (fif.PCselect)
      PCBPC:   target_s = fif.BPC;
      PCPTA:   target_s = fif.PTA;
      PCJPC:   target_s = fif.JPC;
      default: target_s = npc_s;
    endcase
  end

  // PC, deferred redirect and run/halt next state
  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    pend_d  = pend_q;
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (fif.PCEN) begin
          if (fif.PCselect != PCNPC) begin
            pc_d   = target_s;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = redir_q;
            pend_d = 1'b0;
          end else begin
            pc_d   = npc_s;
          end
        end else if (fif.PCselect != PCNPC) begin
          // PC is stalled: remember the latest redirect until the next load
          redir_d = target_s;
          pend_d  = 1'b1;
        end else begin
          pc_d    = pc_q;
        end
        if (fif.WBhalt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // PC / redirect / FSM state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      pc_q    <= PC_RESET;
      redir_q <= {WORD_W{1'b0}};
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      pend_q  <= pend_d;
    end
  end

`ifdef FETCH_BUF_EN
  logic              buf_valid_q, buf_valid_d;
  logic [WORD_W-1:0] buf_word_q, buf_word_d;

  // fetch buffer: capture a hit during an IF/ID stall, drain on the next enable
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    if (!run_s) begin
      buf_valid_d = buf_valid_q;
    end else if (ifid_flush_s | redirect_s) begin
      buf_valid_d = 1'b0;
    end else if (fif.IFIDEN) begin
      buf_valid_d = 1'b0;
    end else if (fif.ihit & ~buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_word_d  = fif.imemload;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // fetch buffer storage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= {WORD_W{1'b0}};
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
    end
  end

  assign ifid_load_s = ~pend_q & (buf_valid_q | fif.ihit);
  assign ifid_word_s = buf_valid_q ? buf_word_q : fif.imemload;
  assign fif.iREN    = run_s & ~buf_valid_q;
`else
  assign ifid_load_s = ~pend_q & fif.ihit;
  assign ifid_word_s = fif.imemload;
  assign fif.iREN    = run_s;
`endif

  if_id_reg #(
    .W (WORD_W)
  ) u_if_id_reg (
    .clk       (CLK),
    .rst       (RST),
    .en        (ifid_en_s),
    .flush     (ifid_flush_s),
    .load      (ifid_load_s),
    .instr_in  (ifid_word_s),
    .npc_in    (npc_s),
    .instr_out (fif.IDinstr),
    .npc_out   (fif.IDnpc),
    .valid_out (fif.IDvalid)
  );

  assign fif.imemaddr = pc_q;
  assign fif.halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic CLK;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  fetch_unit_if #(.WORD_W(32)) fif ();

  fetch_unit #(
    .WORD_W   (32),
    .PC_RESET (32'h0000_0000)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .fif (fif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // behavioural model state
  logic [31:0] m_pc, m_redir, m_instr, m_npc, m_bufw;
  bit          m_pend, m_valid, m_halt, m_bufv;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %08h expected %08h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_redir = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_bufw = 32'h0;
    m_pend = 1'b0; m_valid = 1'b0; m_halt = 1'b0; m_bufv = 1'b0;
  endtask

  task automatic m_step();
    logic [31:0] tgt;
    logic [31:0] seq;
    bit          redirect;
    bit          use_buf;
    if (m_halt) return;
    seq      = m_pc + 32'd4;
    tgt      = (fif.PCselect == PCBPC) ? fif.BPC :
               (fif.PCselect == PCPTA) ? fif.PTA : fif.JPC;
    redirect = fif.PCEN && ((fif.PCselect != PCNPC) || m_pend);
`ifdef FETCH_BUF_EN
    use_buf = m_bufv;
`else
    use_buf = 1'b0;
`endif
    if (fif.IFIDflush) begin
      m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    end else if (fif.IFIDEN) begin
      if (!m_pend && (use_buf || fif.ihit)) begin
        m_instr = use_buf ? m_bufw : fif.imemload;
        m_npc   = seq;
        m_valid = 1'b1;
      end else begin
        m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
      end
    end
`ifdef FETCH_BUF_EN
    if (fif.IFIDflush || redirect || fif.IFIDEN) m_bufv = 1'b0;
    else if (fif.ihit && !m_bufv) begin m_bufv = 1'b1; m_bufw = fif.imemload; end
`endif
    if (fif.PCEN) begin
      m_pc   = (fif.PCselect != PCNPC) ? tgt : (m_pend ? m_redir : seq);
      m_pend = 1'b0;
    end else if (fif.PCselect != PCNPC) begin
      m_redir = tgt;
      m_pend  = 1'b1;
    end
    if (fif.WBhalt) m_halt = 1'b1;
  endtask

  task automatic compare_outputs();
    chk32("imemaddr", fif.imemaddr, m_pc);
    chk1 ("iREN",     fif.iREN,     !m_halt && !m_bufv);
    chk1 ("halted",   fif.halted,   m_halt);
    chk1 ("IDvalid",  fif.IDvalid,  m_valid);
    chk32("IDinstr",  fif.IDinstr,  m_instr);
    if (m_valid) chk32("IDnpc", fif.IDnpc, m_npc);
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RST) m_reset();
    else m_step();
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    m_reset();
    compare_outputs();
    @(posedge CLK);
    @(negedge CLK);
    compare_outputs();
    RST = 1'b0;
  endtask

  task automatic drive(input pcselect_t sel, input bit pcen, input bit ifiden,
                       input bit flush, input bit hit, input logic [31:0] word);
    fif.PCselect  = sel;
    fif.PCEN      = pcen;
    fif.IFIDEN    = ifiden;
    fif.IFIDflush = flush;
    fif.ihit      = hit;
    fif.imemload  = word;
  endtask

  task automatic randomize_inputs();
    logic [1:0] r;
    r = 2'($urandom_range(1, 3));
    fif.PCselect  = ($urandom_range(0, 4) == 0) ? pcselect_t'(r) : PCNPC;
    fif.PCEN      = ($urandom_range(0, 3) != 0);
    fif.IFIDEN    = ($urandom_range(0, 4) != 0);
    fif.IFIDflush = ($urandom_range(0, 9) == 0);
    fif.ihit      = ($urandom_range(0, 3) != 0);
    fif.imemload  = $urandom;
    fif.BPC       = $urandom & 32'hFFFF_FFFC;
    fif.PTA       = $urandom & 32'hFFFF_FFFC;
    fif.JPC       = $urandom & 32'hFFFF_FFFC;
    fif.WBhalt    = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    RST = 1'b1;
    drive(PCNPC, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0001);
    fif.BPC = 32'h0; fif.PTA = 32'h0; fif.JPC = 32'h0; fif.WBhalt = 1'b0;
    m_reset();
    @(negedge CLK);
    do_reset();

    // reset state and sequential fetch
    chk32("rst_pc", fif.imemaddr, 32'h0);
    chk1 ("rst_valid", fif.IDvalid, 1'b0);
    chk32("rst_instr", fif.IDinstr, 32'h0);
    chk1 ("rst_halted", fif.halted, 1'b0);
    chk1 ("rst_iren", fif.iREN, 1'b1);
    cycle();
    chk32("seq_pc4", fif.imemaddr, 32'h4);
    chk32("seq_npc4", fif.IDnpc, 32'h4);
    chk32("seq_instr", fif.IDinstr, 32'hA000_0001);
    chk1 ("seq_valid", fif.IDvalid, 1'b1);
    fif.imemload = 32'hA000_0002;
    cycle();
    chk32("seq_pc8", fif.imemaddr, 32'h8);

    // branch redirect with flush
    fif.BPC = 32'h100;
    drive(PCBPC, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA000_0003);
    cycle();
    chk32("br_pc", fif.imemaddr, 32'h100);
    chk1 ("br_valid", fif.IDvalid, 1'b0);
    chk32("br_instr", fif.IDinstr, 32'h0);

    // deferred jump while PC is stalled
    fif.JPC = 32'h40;
    drive(PCJPC, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB000_0003);
    cycle();
    chk32("jp_hold1", fif.imemaddr, 32'h100);
    cycle();
    chk1 ("jp_bubble2", fif.IDvalid, 1'b0);
    cycle();
    chk1 ("jp_bubble3", fif.IDvalid, 1'b0);
    chk32("jp_hold3", fif.imemaddr, 32'h100);
    drive(PCNPC, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB000_0003);
    cycle();
    chk32("jp_pc", fif.imemaddr, 32'h40);
    chk1 ("jp_bubble4", fif.IDvalid, 1'b0);
    cycle();
    chk32("jp_pc44", fif.imemaddr, 32'h44);
    chk32("jp_npc", fif.IDnpc, 32'h44);
    chk32("jp_instr", fif.IDinstr, 32'hB000_0003);

    // load-use stall
    drive(PCNPC, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0005);
    cycle();
    cycle();
    chk32("st_pc", fif.imemaddr, 32'h44);
    chk32("st_instr", fif.IDinstr, 32'hB000_0003);
`ifdef FETCH_BUF_EN
    chk1 ("st_iren", fif.iREN, 1'b0);
    drive(PCNPC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
`else
    chk1 ("st_iren", fif.iREN, 1'b1);
    drive(PCNPC, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC000_0005);
`endif
    cycle();
    chk32("st_resume_instr", fif.IDinstr, 32'hC000_0005);
    chk32("st_resume_pc", fif.imemaddr, 32'h48);

    // PC wrap
    fif.BPC = 32'hFFFF_FFFC;
    drive(PCBPC, 1'b1, 1'b1, 1'b0, 1'b1, 32'hD000_0006);
    cycle();
    chk32("wr_pc", fif.imemaddr, 32'hFFFF_FFFC);
    drive(PCNPC, 1'b1, 1'b1, 1'b0, 1'b1, 32'hD000_0007);
    cycle();
    chk32("wr_pc0", fif.imemaddr, 32'h0);
    chk32("wr_npc0", fif.IDnpc, 32'h0);
    chk1 ("wr_valid", fif.IDvalid, 1'b1);

    // halt: the halting edge still advances, then everything freezes
    fif.WBhalt = 1'b1;
    cycle();
    chk1 ("ht_halted", fif.halted, 1'b1);
    chk1 ("ht_iren", fif.iREN, 1'b0);
    chk32("ht_pc", fif.imemaddr, 32'h4);
    fif.WBhalt = 1'b0;
    cycle();
    cycle();
    chk32("ht_frozen", fif.imemaddr, 32'h4);
    chk32("ht_npc", fif.IDnpc, 32'h4);
    do_reset();
    chk32("ht_rst_pc", fif.imemaddr, 32'h0);
    chk1 ("ht_rst_halted", fif.halted, 1'b0);

    // randomized traffic with occasional async resets
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        randomize_inputs();
        if ($urandom_range(0, 299) == 0) do_reset();
        else cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
